// File: rtl/aclint_if.sv
// Peripheral-bus request/response bundle between the interconnect and the aclint.
// One request per cycle on valid; the response comes back one cycle later on ready.
interface aclint_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/aclint.sv
// Core-local interruptor: shared mtime advanced by a synchronised rtc tick,
// per-hart msip bits and mtimecmp comparators driving registered mtip.
module aclint #(
  parameter int NUM_HARTS = 4,
  parameter int RTC_SYNC  = 2,
  parameter int TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rtc,
  aclint_if.slave              clint,
  output logic [63:0]          clint_mtime,
  output logic [NUM_HARTS-1:0] clint_msip,
  output logic [NUM_HARTS-1:0] clint_mtip
);

  localparam logic [15:0] DIV_LAST  = 16'(TICK_DIV - 1);
  localparam logic [12:0] MTIME_IDX = 13'h17FF;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  logic [RTC_SYNC-1:0]  rtc_sync;
  logic                 rtc_prev;
  logic [15:0]          presc;
  logic                 rtc_edge;
  logic                 tick;

  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic [NUM_HARTS-1:0] mtip;

  logic [15:0]          off;
  logic                 wr_req;
  logic                 sel_msip;
  logic                 sel_cmp;
  logic                 sel_mtime;
  logic [NUM_HARTS-1:0] hit_msip;
  logic [NUM_HARTS-1:0] hit_cmp;
  logic                 wr_mtime_lo;
  logic                 wr_mtime_hi;
  logic [31:0]          rd_val;

  logic                 rsp_vld_p1;
  logic [31:0]          rsp_data_p1;

  logic                 unused_bits;

  // rtc crossing: synchroniser chain, edge detect, prescaler
  assign rtc_edge = rtc_sync[RTC_SYNC-1] & ~rtc_prev;
  assign tick     = rtc_edge && (presc == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rtc_sync <= '0;
      rtc_prev <= 1'b0;
      presc    <= '0;
    end else begin
      rtc_sync <= {rtc_sync[RTC_SYNC-2:0], rtc};
      rtc_prev <= rtc_sync[RTC_SYNC-1];
      if (rtc_edge) presc <= tick ? 16'd0 : presc + 16'd1;
    end
  end

  // Address decode; an instruction fetch never writes
  assign off       = clint.addr[15:0];
  assign wr_req    = clint.valid && !clint.instr && (clint.wstrb != 4'b0000);
  assign sel_msip  = (off[15:14] == 2'b00);
  assign sel_cmp   = (off[15:14] == 2'b01);
  assign sel_mtime = (off[15:3] == MTIME_IDX);

  assign wr_mtime_lo = wr_req && sel_mtime && !off[2];
  assign wr_mtime_hi = wr_req && sel_mtime &&  off[2];

  always_comb begin
    hit_msip = '0;
    hit_cmp  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hit_msip[h] = sel_msip && (off[13:2] == 12'(h));
      hit_cmp[h]  = sel_cmp  && (off[13:3] == 11'(h));
    end
  end

  // Unmatched offsets and absent harts fall through to zero
  always_comb begin
    rd_val = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hit_msip[h]) rd_val = {31'b0, msip[h]};
      if (hit_cmp[h])  rd_val = off[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
    if (sel_mtime) rd_val = off[2] ? mtime[63:32] : mtime[31:0];
  end

  // A bus write to either half of mtime takes priority over a same-cycle tick
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime[31:0]  <= merge_bytes(mtime[31:0],  clint.wdata, clint.wstrb);
      if (wr_mtime_hi) mtime[63:32] <= merge_bytes(mtime[63:32], clint.wdata, clint.wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msip <= '0;
      mtip <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_req && hit_msip[h] && clint.wstrb[0]) msip[h] <= clint.wdata[0];
        if (wr_req && hit_cmp[h]) begin
          if (off[2]) mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], clint.wdata, clint.wstrb);
          else        mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0],  clint.wdata, clint.wstrb);
        end
        mtip[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  // Response stage: read data reflects state before this cycle's updates
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
    end else begin
      rsp_vld_p1  <= clint.valid;
      rsp_data_p1 <= clint.valid ? rd_val : 32'd0;
    end
  end

  assign clint.ready = rsp_vld_p1;
  assign clint.rdata = rsp_data_p1;
  assign clint_mtime = mtime;
  assign clint_msip  = msip;
  assign clint_mtip  = mtip;

  assign unused_bits = ^{clint.addr[31:16], off[1:0]};

endmodule

// File: tb/tb_aclint.sv
// Self-checking bench for aclint: directed scenarios plus a randomized
// register-access run scored against a behavioural register-map model.
module tb_aclint;
  localparam int NH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rtc = 1'b0;
  logic [63:0]   mtime;
  logic [NH-1:0] msip;
  logic [NH-1:0] mtip;

  aclint_if bus ();

  aclint #(.NUM_HARTS(NH), .RTC_SYNC(2), .TICK_DIV(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .rtc         (rtc),
    .clint       (bus),
    .clint_mtime (mtime),
    .clint_msip  (msip),
    .clint_mtip  (mtip)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the register map and time base
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;
  int            m_pre;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mtime = 64'd0;
    m_msip  = '0;
    m_pre   = 0;
    for (int h = 0; h < NH; h++) m_cmp[h] = {64{1'b1}};
  endtask

  function automatic logic [NH-1:0] model_mtip();
    logic [NH-1:0] r;
    for (int h = 0; h < NH; h++) r[h] = (m_mtime >= m_cmp[h]);
    return r;
  endfunction

  // Returns the pre-access value, then applies the byte-lane write
  task automatic model_access(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rd);
    int o;
    int h;
    int hi;
    o  = {16'b0, a[15:0]};
    hi = (o >> 2) & 1;
    rd = 32'd0;
    if (o < 'h4000) begin
      h = o / 4;
      if (h < NH) begin
        rd = {31'b0, m_msip[h]};
        if (s[0]) m_msip[h] = d[0];
      end
    end else if (o < 'h8000) begin
      h = (o - 'h4000) / 8;
      if (h < NH) begin
        rd = hi ? m_cmp[h][63:32] : m_cmp[h][31:0];
        for (int i = 0; i < 4; i++)
          if (s[i]) m_cmp[h][hi*32 + 8*i +: 8] = d[8*i +: 8];
      end
    end else if (o >= 'hBFF8 && o < 'hC000) begin
      rd = hi ? m_mtime[63:32] : m_mtime[31:0];
      for (int i = 0; i < 4; i++)
        if (s[i]) m_mtime[hi*32 + 8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic bus_op(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic rdy);
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = s;
    step();
    rdy = bus.ready;
    rd  = bus.rdata;
    bus.valid = 1'b0;
    bus.wstrb = 4'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.valid = 1'b0;
    rtc       = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rtc_pulse();
    rtc = 1'b1;
    repeat (3) step();
    rtc = 1'b0;
    repeat (3) step();
    m_pre++;
    if (m_pre == 3) begin
      m_pre   = 0;
      m_mtime = m_mtime + 64'd1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rdy;
    do_reset();
    checks++;
    if (bus.ready !== 1'b0 || bus.rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b rdata=%h required ready=0 rdata=0", bus.ready, bus.rdata);
    end
    bus_op(32'h0000_0000, 32'd0, 4'b0, rd, rdy);
    checks++;
    if (rdy !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_msip0: ready=%b rdata=%h required 1/00000000", rdy, rd);
    end
    bus_op(32'h0000_4000, 32'd0, 4'b0, rd, rdy);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_cmp0_lo: got %h required ffffffff", rd);
    end
    bus_op(32'h0000_4004, 32'd0, 4'b0, rd, rdy);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_cmp0_hi: got %h required ffffffff", rd);
    end
    bus_op(32'h0000_BFF8, 32'd0, 4'b0, rd, rdy);
    checks++;
    if (rd !== 32'd0 || mtime !== 64'd0) begin
      errors++;
      $display("FAIL reset_mtime: rdata=%h mtime=%h required 0", rd, mtime);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (mtip !== '0) begin
        errors++;
        $display("FAIL reset_mtip cycle %0d: got %b required 0000", c, mtip);
      end
    end
  endtask

  task automatic test_byte_strobes();
    logic [31:0] rd;
    logic        rdy;
    do_reset();
    bus_op(32'h0000_4010, 32'h1234_5678, 4'b0101, rd, rdy);
    bus_op(32'h0000_4010, 32'd0, 4'b0, rd, rdy);
    checks++;
    if (rd !== 32'hFF34_FF78) begin
      errors++;
      $display("FAIL strobe_cmp2_lo: got %h required ff34ff78", rd);
    end
    bus_op(32'h0000_0014, 32'd1, 4'b1111, rd, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL strobe_hart5_wr_ready: got %b required 1", rdy);
    end
    bus_op(32'h0000_0014, 32'd0, 4'b0, rd, rdy);
    checks++;
    if (rdy !== 1'b1 || rd !== 32'd0 || msip !== '0) begin
      errors++;
      $display("FAIL strobe_hart5_rd: ready=%b rdata=%h msip=%b required 1/0/0000", rdy, rd, msip);
    end
  endtask

  task automatic test_random_access();
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] o16;
    logic [31:0] exp_rd;
    logic [31:0] rd;
    logic        rdy;
    int          kind;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       o16 = 16'(4 * $urandom_range(0, 7));
        1:       o16 = 16'('h4000 + 8 * $urandom_range(0, 5) + 4 * $urandom_range(0, 1));
        2:       o16 = 16'('hBFF8 + 4 * $urandom_range(0, 1));
        default: o16 = 16'('h8000 + 4 * $urandom_range(0, 'hFFD));
      endcase
      a = {16'($urandom), o16[15:2], 2'($urandom)};
      d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      model_access(a, d, s, exp_rd);
      bus_op(a, d, s, rd, rdy);
      checks++;
      if (rdy !== 1'b1 || rd !== exp_rd) begin
        errors++;
        $display("FAIL rand_rd #%0d addr=%h strb=%b: ready=%b rdata=%h required 1/%h", n, a, s, rdy, rd, exp_rd);
      end
      checks++;
      if (mtime !== m_mtime || msip !== m_msip) begin
        errors++;
        $display("FAIL rand_state #%0d: mtime=%h msip=%b required %h/%b", n, mtime, msip, m_mtime, m_msip);
      end
      step();
      checks++;
      if (mtip !== model_mtip()) begin
        errors++;
        $display("FAIL rand_mtip #%0d: got %b required %b", n, mtip, model_mtip());
      end
    end
  endtask

  task automatic test_timer_fire();
    logic [31:0] rd;
    logic        rdy;
    int          t;
    int          t5;
    int          tm;
    int          others;
    do_reset();
    bus_op(32'h0000_4008, 32'd5, 4'b1111, rd, rdy);
    bus_op(32'h0000_400C, 32'd0, 4'b1111, rd, rdy);
    t = 0; t5 = -1; tm = -1; others = 0;
    for (int e = 0; e < 15; e++) begin
      for (int c = 0; c < 6; c++) begin
        rtc = (c < 3);
        step();
        t++;
        if (mtime == 64'd5 && t5 < 0) t5 = t;
        if (mtip[1] && tm < 0) tm = t;
        if ((mtip & 4'b1101) != 4'b0000) others++;
      end
    end
    rtc = 1'b0;
    m_mtime = 64'd5;
    m_pre   = 0;
    checks++;
    if (mtime !== 64'd5) begin
      errors++;
      $display("FAIL timer_mtime: got %h required 5", mtime);
    end
    checks++;
    if (t5 < 0 || tm !== t5 + 1) begin
      errors++;
      $display("FAIL timer_mtip_latency: mtip1 rose at %0d, mtime=5 at %0d, required one cycle later", tm, t5);
    end
    checks++;
    if (others !== 0) begin
      errors++;
      $display("FAIL timer_other_mtip: %0d cycles with other bits set, required 0", others);
    end
  endtask

  task automatic test_collision();
    do_reset();
    rtc_pulse();
    rtc_pulse();
    checks++;
    if (mtime !== 64'd0) begin
      errors++;
      $display("FAIL collide_pre: mtime=%h required 0", mtime);
    end
    rtc = 1'b1;
    step();
    step();
    bus.valid = 1'b1;
    bus.addr  = 32'h0000_BFF8;
    bus.wdata = 32'h0000_0100;
    bus.wstrb = 4'b1111;
    step();
    bus.valid = 1'b0;
    bus.wstrb = 4'b0;
    checks++;
    if (mtime !== 64'h100 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL collide_write: mtime=%h ready=%b required 100/1", mtime, bus.ready);
    end
    step();
    checks++;
    if (mtime !== 64'h100) begin
      errors++;
      $display("FAIL collide_no_inc: mtime=%h required 100", mtime);
    end
    rtc = 1'b0;
    repeat (3) step();
    m_pre   = 0;
    m_mtime = 64'h100;
    rtc_pulse();
    rtc_pulse();
    checks++;
    if (mtime !== m_mtime) begin
      errors++;
      $display("FAIL collide_presc_hold: mtime=%h required %h", mtime, m_mtime);
    end
    rtc_pulse();
    checks++;
    if (mtime !== m_mtime) begin
      errors++;
      $display("FAIL collide_presc_wrap: mtime=%h required %h", mtime, m_mtime);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic        rdy;
    int          drops;
    do_reset();
    bus_op(32'h0000_4000, 32'd0, 4'b1111, rd, rdy);
    bus_op(32'h0000_4004, 32'd0, 4'b1111, rd, rdy);
    bus_op(32'h0000_BFF8, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
    bus_op(32'h0000_BFFC, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
    step();
    checks++;
    if (mtime !== {64{1'b1}} || mtip[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_setup: mtime=%h mtip0=%b required all-ones/1", mtime, mtip[0]);
    end
    drops = 0;
    for (int e = 0; e < 3; e++) begin
      for (int c = 0; c < 6; c++) begin
        rtc = (c < 3);
        step();
        if (mtip[0] !== 1'b1) drops++;
      end
    end
    rtc = 1'b0;
    checks++;
    if (mtime !== 64'd0) begin
      errors++;
      $display("FAIL wrap_mtime: got %h required 0", mtime);
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL wrap_mtip0: dropped for %0d cycles, required 0", drops);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.valid = 1'b1;
    bus.addr  = 32'h0000_000C;
    bus.wdata = 32'd0;
    bus.wstrb = 4'b0;
    step();
    checks++;
    if (bus.ready !== 1'b1 || bus.rdata !== 32'd0 || msip !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_read: ready=%b rdata=%h msip=%b required 1/0/0000", bus.ready, bus.rdata, msip);
    end
    bus.wdata = 32'd1;
    bus.wstrb = 4'b0001;
    step();
    bus.valid = 1'b0;
    bus.wstrb = 4'b0;
    checks++;
    if (bus.ready !== 1'b1 || msip !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_write: ready=%b msip=%b required 1/1000", bus.ready, msip);
    end
    step();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b required 0", bus.ready);
    end
  endtask

  task automatic test_reset_mid();
    bus.valid = 1'b1;
    bus.addr  = 32'h0000_000C;
    bus.wstrb = 4'b0;
    rst       = 1'b1;
    step();
    bus.valid = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.rdata !== 32'd0 || msip !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: ready=%b rdata=%h msip=%b required 0/0/0000", bus.ready, bus.rdata, msip);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.instr = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    bus.wstrb = 4'b0;
    model_reset();
    test_reset();
    test_byte_strobes();
    test_random_access();
    test_timer_fire();
    test_collision();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end
endmodule
